fip_32_det3x3_pipe: RTL and testbench



---
 rtl/fip_32_det3x3_pipe.sv | 98 +++++++++
 tb/tb_fip_32_det3x3_pipe.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fip_32_det3x3_pipe.sv
// rtl/fip_32_det3x3_pipe.sv - pipelined 3x3 determinant of signed Q16.16 matrices
//
// Purpose: computes det(M) for one 3x3 fixed-point matrix per clock with a
//          fixed latency of 3 cycles (sample edge N -> result after edge N+3).
// Ports:
//   i_clk    clock, all state on the rising edge
//   i_rstn   synchronous active-low reset
//   i_en     i_array carries a valid matrix this cycle
//   i_array  signed [31:0] matrix [row][col], Q16.16
//   o_det    signed [31:0] determinant, Q16.16 (holds between results)
//   o_valid  o_det carries a new result this cycle
// Configuration macro: FIP_DET_SAT_EN - saturate the result to 32 bits
//          instead of two's-complement wrap.

module fip_32_det3x3_pipe #(
    parameter int FRA_BITS = 16
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_en,
    input  logic signed [31:0] i_array [0:2][0:2],
    output logic signed [31:0] o_det,
    output logic               o_valid
);

    // Valid shift register: bit k travels alongside pipeline level k.
    logic [2:0] vld;

    // Level 0: 2x2 minors' products of rows 1-2, plus a copy of row 0.
    logic signed [63:0] p_11_22, p_12_21, p_10_22, p_12_20, p_10_21, p_11_20;
    logic signed [31:0] row0_a [0:2];

    // Level 1: cofactors (one bit wider than the products to absorb the
    // subtraction), row 0 carried along.
    logic signed [64:0] cof0, cof1, cof2;
    logic signed [31:0] row0_b [0:2];

    // Level 2: scaled terms m0j * cj.
    logic signed [96:0] term0, term1, term2;

    logic signed [31:0] det_next;

    // Data path registers carry no reset; validity is tracked by vld alone.
    always_ff @(posedge i_clk) begin
        p_11_22 <= (64'(i_array[1][1]) * 64'(i_array[2][2])) >>> FRA_BITS;
        p_12_21 <= (64'(i_array[1][2]) * 64'(i_array[2][1])) >>> FRA_BITS;
        p_10_22 <= (64'(i_array[1][0]) * 64'(i_array[2][2])) >>> FRA_BITS;
        p_12_20 <= (64'(i_array[1][2]) * 64'(i_array[2][0])) >>> FRA_BITS;
        p_10_21 <= (64'(i_array[1][0]) * 64'(i_array[2][1])) >>> FRA_BITS;
        p_11_20 <= (64'(i_array[1][1]) * 64'(i_array[2][0])) >>> FRA_BITS;
        row0_a  <= i_array[0];

        cof0   <= 65'(p_11_22) - 65'(p_12_21);
        cof1   <= 65'(p_10_22) - 65'(p_12_20);
        cof2   <= 65'(p_10_21) - 65'(p_11_20);
        row0_b <= row0_a;

        term0 <= (97'(row0_b[0]) * 97'(cof0)) >>> FRA_BITS;
        term1 <= (97'(row0_b[1]) * 97'(cof1)) >>> FRA_BITS;
        term2 <= (97'(row0_b[2]) * 97'(cof2)) >>> FRA_BITS;
    end

`ifdef FIP_DET_SAT_EN
    localparam logic signed [98:0] SAT_MAX = 99'sd2147483647;
    localparam logic signed [98:0] SAT_MIN = -99'sd2147483648;

    logic signed [98:0] sum;

    always_comb begin
        sum      = 99'(term0) - 99'(term1) + 99'(term2);
        det_next = sum[31:0];
        if (sum > SAT_MAX) begin
            det_next = 32'sh7FFFFFFF;
        end else if (sum < SAT_MIN) begin
            det_next = 32'sh80000000;
        end
    end
`else
    // The low 32 bits of the full-width sum only depend on the low bits of
    // the terms, so the wrap result is taken straight from the 97-bit sum.
    assign det_next = 32'(term0 - term1 + term2);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            vld     <= '0;
            o_valid <= 1'b0;
            o_det   <= '0;
        end else begin
            vld     <= {vld[1:0], i_en};
            o_valid <= vld[2];
            if (vld[2]) begin
                o_det <= det_next;
            end
        end
    end

endmodule

// File: tb/tb_fip_32_det3x3_pipe.sv
// tb/tb_fip_32_det3x3_pipe.sv - self-checking bench for fip_32_det3x3_pipe

module tb_fip_32_det3x3_pipe;

    localparam int MAX_EDGES = 512;

    logic               clk = 1'b0;
    logic               rstn;
    logic               en;
    logic signed [31:0] arr [0:2][0:2];
    logic signed [31:0] det;
    logic               valid;

    always #5 clk = ~clk;

    fip_32_det3x3_pipe #(.FRA_BITS(16)) dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_en    (en),
        .i_array (arr),
        .o_det   (det),
        .o_valid (valid)
    );

    typedef struct {
        logic signed [31:0] m [9];
        logic               en;
        logic signed [31:0] expv;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-edge history of what was sampled: a result issued at edge s is due
    // at edge s+3 unless a reset edge falls in (s, s+3].
    bit                 h_vld [0:MAX_EDGES];
    logic signed [31:0] h_det [0:MAX_EDGES];
    bit                 h_rst [0:MAX_EDGES];
    int                 n_edge = 0;
    logic signed [31:0] m_det;
    bit                 m_det_known = 1'b0;

    function automatic logic signed [127:0] fx(input logic signed [127:0] a,
                                               input logic signed [127:0] b);
        return (a * b) >>> 16;
    endfunction

    function automatic logic signed [31:0] ref_det(input logic signed [31:0] m [9]);
        logic signed [127:0] a [9];
        logic signed [127:0] s;
        for (int i = 0; i < 9; i++) a[i] = 128'(m[i]);
        s = fx(a[0], fx(a[4], a[8]) - fx(a[5], a[7]))
          - fx(a[1], fx(a[3], a[8]) - fx(a[5], a[6]))
          + fx(a[2], fx(a[3], a[7]) - fx(a[4], a[6]));
`ifdef FIP_DET_SAT_EN
        if (s > 128'sd2147483647) return 32'sh7FFFFFFF;
        if (s < -128'sd2147483648) return 32'sh80000000;
`endif
        return s[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s edge=%0d actual=%h required=%h", name, n_edge, act, req);
        end
    endtask

    // Drive one cycle at the falling edge, let the rising edge sample it,
    // then compare outputs at the next falling edge.
    task automatic cycle(input logic r, input logic e_in,
                         input logic signed [31:0] m [9], input logic signed [31:0] d);
        bit exp_v;
        rstn = r;
        en   = e_in;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                arr[i][j] = m[i*3+j];
        @(posedge clk);
        n_edge++;
        h_rst[n_edge] = !r;
        h_vld[n_edge] = e_in && r;
        h_det[n_edge] = d;
        if (!r) begin
            for (int k = 1; k <= 3; k++)
                if (n_edge - k >= 0) h_vld[n_edge-k] = 1'b0;
        end
        @(negedge clk);
        exp_v = (n_edge >= 3) ? h_vld[n_edge-3] : 1'b0;
        if (h_rst[n_edge]) begin
            m_det       = '0;
            m_det_known = 1'b1;
        end else if (exp_v) begin
            m_det       = h_det[n_edge-3];
            m_det_known = 1'b1;
        end
        check("o_valid", {31'd0, valid}, {31'd0, exp_v});
        if (m_det_known) check("o_det", det, m_det);
    endtask

    logic signed [31:0] zero_m [9];
    logic signed [31:0] ident [9];
    logic signed [31:0] neg_id [9];
    logic signed [31:0] m_a [9];
    logic signed [31:0] rnd [9];
    vec_t tbl [9];

    initial begin
        for (int i = 0; i < 9; i++) zero_m[i] = '0;
        ident  = '{32'h10000, 0, 0, 0, 32'h10000, 0, 0, 0, 32'h10000};
        neg_id = '{-65536, 0, 0, 0, -65536, 0, 0, 0, -65536};
        m_a    = '{65536, -65536, 196608, 262144, 327680, 393216, 458752, 524288, 589824};

        tbl[0].m = ident;  tbl[0].en = 1'b1; tbl[0].expv = 32'h00010000;
        tbl[1].m = zero_m; tbl[1].en = 1'b0; tbl[1].expv = '0;
        tbl[2].m = '{65536, 131072, 196608, 262144, 327680, 393216, 458752, 524288, 589824};
        tbl[2].en = 1'b1; tbl[2].expv = 32'h00000000;
        tbl[3].m = m_a;    tbl[3].en = 1'b1; tbl[3].expv = 32'hFFEE0000;
        tbl[4].m = zero_m; tbl[4].en = 1'b0; tbl[4].expv = '0;
        tbl[5].m = '{32'h01000000, 0, 0, 0, 32'h01000000, 0, 0, 0, 32'h01000000};
        tbl[5].en = 1'b1;
`ifdef FIP_DET_SAT_EN
        tbl[5].expv = 32'h7FFFFFFF;
`else
        tbl[5].expv = 32'h00000000;
`endif
        tbl[6].m = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        tbl[6].en = 1'b1; tbl[6].expv = 32'h00000000;
        tbl[7].m = neg_id; tbl[7].en = 1'b1; tbl[7].expv = 32'hFFFF0000;
        tbl[8].m = zero_m; tbl[8].en = 1'b0; tbl[8].expv = '0;

        rstn = 1'b0;
        en   = 1'b0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                arr[i][j] = '0;
        @(negedge clk);

        cycle(1'b0, 1'b0, zero_m, '0);
        cycle(1'b0, 1'b0, zero_m, '0);

        // Directed vectors, back-to-back with bubbles and a hold check.
        for (int v = 0; v < 9; v++) cycle(1'b1, tbl[v].en, tbl[v].m, tbl[v].expv);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, zero_m, '0);

        // Reset with two results in flight (and an enable during reset).
        cycle(1'b1, 1'b1, ident, 32'h00010000);
        cycle(1'b1, 1'b1, neg_id, 32'hFFFF0000);
        cycle(1'b0, 1'b1, m_a, 32'hFFEE0000);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, zero_m, '0);
        cycle(1'b1, 1'b1, m_a, 32'hFFEE0000);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, zero_m, '0);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 80; n++) begin
            logic r_v;
            logic e_v;
            for (int i = 0; i < 9; i++) begin
                if ($urandom_range(0, 3) == 0) rnd[i] = $urandom;
                else rnd[i] = int'($urandom_range(0, 1048575)) - 524288;
            end
            r_v = ($urandom_range(0, 24) != 0);
            e_v = ($urandom_range(0, 3) != 0);
            cycle(r_v, e_v, rnd, ref_det(rnd));
        end
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, zero_m, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
